key_expansion_128: RTL and testbench
====================================

Name: key_expansion_128

Overview:
Sequential AES-128 key schedule. Accepts a 128-bit cipher key on a start pulse and emits the 11 round keys (round 0..10), one per clock, on a registered valid/index stream. The round datapath (cipher round or key store) consumes this stream. Per round it forms RotWord of the last word, passes it through the existing combinational subword S-box block, then applies Rcon and the word XOR chain.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; fixed at 10 for AES-128 and not intended to be overridden.

Ports:
clk        input   1    single clock; all state updates on its rising edge
rst        input   1    asynchronous, active-high reset
start      input   1    request to expand key_in; sampled only when busy==0
key_in     input   128  cipher key; bits [127:96]=w0 ... [31:0]=w3
busy       output  1    expansion in progress; start is ignored while high
rk_valid   output  1    round_key / rk_idx are valid this cycle
rk_idx     output  4    round number of round_key, 0..10
round_key  output  128  round key; [127:96]=w(4i) ... [31:0]=w(4i+3)
done       output  1    one-cycle pulse, coincident with rk_idx==10 and rk_valid

Behaviour:
- Reset is asynchronous, active-high. On reset: state=IDLE, busy=0, rk_valid=0, rk_idx=0, round_key=0, done=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM has two states, IDLE and EXPAND.
- IDLE with start=1 (cycle T), at the edge ending T:
  - key_reg<=key_in, round_key<=key_in, rk_idx<=0
  - rk_valid<=1, busy<=1, state<=EXPAND
  - Round key 0 is therefore visible in cycle T+1 (latency 1).
- EXPAND with rk_idx<10, at each edge:
  - round_key<=next_key, rk_idx<=rk_idx+1
  - rk_valid stays 1, with no gaps. Round i appears in cycle T+1+i.
- EXPAND with rk_idx==9: done<=1 in addition, so done is high with rk_idx==10.
- EXPAND with rk_idx==10, at the edge: rk_valid<=0, busy<=0, done<=0, state<=IDLE. rk_idx and round_key hold their last values.
- next_key, computed from the current round_key w0..w3:
  - t = SubWord({w3[23:0], w3[31:24]}) ^ {rcon[rk_idx], 24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - The whole round is evaluated combinationally within one cycle.
- rcon[0..9] = 01,02,04,08,10,20,40,80,1b,36 (hex). The index is the current rk_idx (the round being left).
- start while busy=1 is ignored. No queuing, and the in-flight expansion is unaffected.
- key_in is sampled only in the accepting cycle. Later changes have no effect.
- Back-to-back expansions: busy falls in cycle T+12, so a start held high there is accepted and round 0 of the new key appears at T+13. Minimum start-to-start spacing is 12 cycles.
- rst asserted mid-expansion: outputs return to reset values immediately (asynchronous). After release, the block is IDLE and the next start begins a fresh expansion.
- Downstream has no backpressure. The consumer must capture each round key in its valid cycle.

Decomposition:
- Shared package aes_pkg:
  - AES_KEY_W=128, AES_WORD_W=32, AES128_ROUNDS=10
  - the Rcon constant array (10 x 8-bit)
  - the FSM state enum {IDLE, EXPAND}
- The FSM, the rk_idx counter, the registers and the XOR chain stay in key_expansion_128.
- One sub-module instance: subword, on the rotated w3. No other sub-modules.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
  - round 0 = key at T+1
  - round 1 = a0fafe1788542cb123a339392a6c7605 at T+2
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1 at T+11
  - busy=0 at T+12
- All-zero key:
  - round 1 = 62636363626363636263636362636363
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e
  - rk_idx must step 0..10 with no valid gaps.
- Start pulsed at T+4 during the FIPS expansion with key_in=ffff...ff: the stream is identical to the first scenario, and exactly one done pulse is seen.
- start held high continuously with alternating keys:
  - each accept is 12 cycles apart
  - the second round-0 key equals key_in as sampled at T+12
  - 11 valids per expansion.
- rst asserted at T+6 (rk_idx=5) for 1 cycle:
  - immediate busy=0, rk_valid=0, round_key=0, done=0
  - a subsequent start with the FIPS key reproduces the full correct stream.
- Reset-value check with no start ever asserted: all outputs stay 0 for 50 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, round-constant table and key-schedule FSM state type.
package aes_pkg;

   localparam int AES_KEY_W     = 128;
   localparam int AES_WORD_W    = 32;
   localparam int AES128_ROUNDS = 10;

   // Entry i is the Rcon byte used when leaving round key i.
   localparam logic [0:AES128_ROUNDS-1][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   typedef enum logic {
      IDLE,
      EXPAND
   } state_e;

endpackage

// File: rtl/key_expansion_128_if.sv
// Key-schedule request and round-key stream bundle; master drives start/key_in.
interface key_expansion_128_if;
   import aes_pkg::*;

   logic                 start;
   logic [AES_KEY_W-1:0] key_in;
   logic                 busy;
   logic                 rk_valid;
   logic [3:0]           rk_idx;
   logic [AES_KEY_W-1:0] round_key;
   logic                 done;

   modport master (
      output start, key_in,
      input  busy, rk_valid, rk_idx, round_key, done
   );

   modport slave (
      input  start, key_in,
      output busy, rk_valid, rk_idx, round_key, done
   );

endinterface

// File: rtl/key_expansion_128_subword.sv
// Combinational AES SubWord: four parallel forward S-box lookups, one per byte.
module key_expansion_128_subword
   import aes_pkg::*;
(
   input  logic [AES_WORD_W-1:0] word_i,
   output logic [AES_WORD_W-1:0] word_o
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign word_o = {SBOX[word_i[31:24]], SBOX[word_i[23:16]],
                    SBOX[word_i[15:8]],  SBOX[word_i[7:0]]};

endmodule

// File: rtl/key_expansion_128.sv
// Sequential AES-128 key schedule: round keys 0..10 streamed one per clock, first one cycle after start.
// No backpressure; start is ignored while busy and the consumer must take each key in its valid cycle.
module key_expansion_128
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES128_ROUNDS
)(
   input  logic                clk,
   input  logic                rst,
   key_expansion_128_if.slave  bus
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

   state_e               state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic                 done_q, done_d;
   logic [3:0]           idx_q, idx_d;
   logic [AES_KEY_W-1:0] rk_q, rk_d;

   logic [AES_WORD_W-1:0] w0, w1, w2, w3;
   logic [AES_WORD_W-1:0] rot_w, sub_w, t_w;
   logic [AES_WORD_W-1:0] n0, n1, n2, n3;
   logic [7:0]            rcon_b;
   logic [AES_KEY_W-1:0]  next_key;

   assign {w0, w1, w2, w3} = rk_q;
   assign rot_w = {w3[23:0], w3[31:24]};

   key_expansion_128_subword u_subword (
      .word_i (rot_w),
      .word_o (sub_w)
   );

   // Past the last round the Rcon lookup is out of table range; next_key is unused there anyway.
   assign rcon_b   = (idx_q < LAST_IDX) ? RCON[idx_q] : 8'h00;
   assign t_w      = sub_w ^ {rcon_b, 24'h000000};
   assign n0       = w0 ^ t_w;
   assign n1       = w1 ^ n0;
   assign n2       = w2 ^ n1;
   assign n3       = w3 ^ n2;
   assign next_key = {n0, n1, n2, n3};

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      idx_d   = idx_q;
      rk_d    = rk_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               rk_d    = bus.key_in;
               idx_d   = 4'd0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               state_d = EXPAND;
            end
         end
         EXPAND: begin
            if (idx_q < LAST_IDX) begin
               rk_d   = next_key;
               idx_d  = idx_q + 4'd1;
               done_d = (idx_q == LAST_IDX - 4'd1);
            end else begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= 4'd0;
         rk_q    <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         idx_q   <= idx_d;
         rk_q    <= rk_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.rk_valid  = valid_q;
   assign bus.rk_idx    = idx_q;
   assign bus.round_key = rk_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_key_expansion_128.sv
// Bench for key_expansion_128: vector table plus scoreboard fed from an S-box built by GF(2^8) inversion.
module tb_key_expansion_128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   key_expansion_128_if kif ();

   key_expansion_128 dut (
      .clk (clk),
      .rst (rst),
      .bus (kif)
   );

   typedef struct {
      logic [3:0]   idx;
      logic [127:0] key;
   } exp_t;

   typedef struct {
      logic [127:0] key;
      logic [127:0] r1;
      logic [127:0] r10;
   } vec_t;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] ALT_KEY  = 128'h000102030405060708090a0b0c0d0e0f;

   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;
   exp_t q[$];
   logic [7:0] sb [256];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = xtime(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] x, inv;
      for (int i = 0; i < 256; i++) begin
         x   = 8'(i);
         inv = 8'h00;
         if (x != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, x);
         end
         sb[i] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] m_next(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w [4];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      t = {sb[w[3][23:16]] ^ rc, sb[w[3][15:8]], sb[w[3][7:0]], sb[w[3][31:24]]};
      w[0] = w[0] ^ t;
      for (int i = 1; i < 4; i++) w[i] = w[i] ^ w[i-1];
      return {w[0], w[1], w[2], w[3]};
   endfunction

   task automatic push_expected(input logic [127:0] key);
      logic [127:0] rk = key;
      logic [7:0]   rc = 8'h01;
      for (int i = 0; i <= 10; i++) begin
         q.push_back('{idx: 4'(i), key: rk});
         rk = m_next(rk, rc);
         rc = xtime(rc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (kif.done) done_cnt++;
      if (kif.rk_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: valid with idx %0d key %h, no entry expected", kif.rk_idx, kif.round_key);
         end else begin
            e = q.pop_front();
            chk("sb_idx", 128'(kif.rk_idx), 128'(e.idx));
            chk("sb_key", kif.round_key, e.key);
         end
      end
   end

   // One start pulse, then cycle-exact checks over T+1..T+12; optional foreign start at T+4.
   task automatic run_stream(input vec_t v, input bit inject);
      int d0;
      push_expected(v.key);
      d0 = done_cnt;
      @(posedge clk); #1;
      kif.start  = 1'b1;
      kif.key_in = v.key;
      @(posedge clk); #1;
      kif.start  = 1'b0;
      kif.key_in = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (inject && c == 4) begin
            kif.start  = 1'b1;
            kif.key_in = '1;
         end
         if (inject && c == 5) kif.start = 1'b0;
         chk("rk_valid", 128'(kif.rk_valid), 128'(c <= 11));
         chk("busy", 128'(kif.busy), 128'(c <= 11));
         chk("done", 128'(kif.done), 128'(c == 11));
         chk("rk_idx", 128'(kif.rk_idx), (c <= 11) ? 128'(c - 1) : 128'd10);
         if (c == 2)  chk("round1", kif.round_key, v.r1);
         if (c == 11) chk("round10", kif.round_key, v.r10);
         if (c == 12) chk("round10_hold", kif.round_key, v.r10);
      end
      chk("done_pulses", 128'(done_cnt - d0), 128'd1);
      chk("sb_drained", 128'(q.size()), 128'd0);
   endtask

   vec_t vecs [2];

   initial begin
      int nz;
      int n1, n2;
      int acc[$];

      vecs[0] = '{key: FIPS_KEY,
                  r1:  128'ha0fafe1788542cb123a339392a6c7605,
                  r10: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[1] = '{key: 128'h0,
                  r1:  128'h62636363626363636263636362636363,
                  r10: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      kif.start  = 1'b0;
      kif.key_in = '0;
      build_sbox();

      repeat (2) @(posedge clk);
      #1;
      chk("rst_outputs", {kif.busy, kif.rk_valid, kif.done, kif.rk_idx, kif.round_key[119:0]}, 128'd0);
      rst = 1'b0;

      nz = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if ({kif.busy, kif.rk_valid, kif.done, kif.rk_idx} != 0 || kif.round_key != 0) nz++;
      end
      chk("idle_zero_50", 128'(nz), 128'd0);

      for (int i = 0; i < 2; i++) run_stream(vecs[i], 1'b0);

      run_stream(vecs[0], 1'b1);

      // start held high with alternating keys: accepts at T and T+12 only
      n1 = 0;
      n2 = 0;
      push_expected(FIPS_KEY);
      @(posedge clk); #1;
      kif.start  = 1'b1;
      kif.key_in = FIPS_KEY;
      for (int c = 1; c <= 27; c++) begin
         @(posedge clk); #1;
         kif.start  = (c <= 23);
         kif.key_in = (c % 2 == 1) ? ALT_KEY : FIPS_KEY;
         if (c == 12) push_expected(kif.key_in);
         @(negedge clk);
         if (kif.rk_valid) begin
            if (c <= 12) n1++;
            else n2++;
            if (kif.rk_idx == 4'd0) acc.push_back(c);
         end
      end
      kif.start = 1'b0;
      chk("held_accepts", 128'(acc.size()), 128'd2);
      if (acc.size() >= 2) begin
         chk("held_first_accept", 128'(acc[0]), 128'd1);
         chk("held_spacing", 128'(acc[1] - acc[0]), 128'd12);
      end
      chk("held_valids_1", 128'(n1), 128'd11);
      chk("held_valids_2", 128'(n2), 128'd11);
      chk("held_drained", 128'(q.size()), 128'd0);

      // asynchronous reset in the middle of an expansion
      push_expected(FIPS_KEY);
      @(posedge clk); #1;
      kif.start  = 1'b1;
      kif.key_in = FIPS_KEY;
      @(posedge clk); #1;
      kif.start  = 1'b0;
      for (int c = 1; c <= 6; c++) @(negedge clk);
      chk("mid_idx", 128'(kif.rk_idx), 128'd5);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_ctrl", 128'({kif.busy, kif.rk_valid, kif.done}), 128'd0);
      chk("mid_rst_key", kif.round_key, 128'd0);
      chk("mid_rst_idx", 128'(kif.rk_idx), 128'd0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      run_stream(vecs[0], 1'b0);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
